// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Bundle of the IF / DM requester ports and the unified memory
//            command port served by mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // Data memory requester
  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_we;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;
  // Unified memory command / return
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  // Status
  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, dm_we, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_addr, mem_we, mem_wdata, busy
  );

  // Requesters plus memory side
  modport master (
    output if_req, if_addr, dm_req, dm_addr, dm_we, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_addr, mem_we, mem_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one single-port memory between instruction fetch and data
//            memory requesters. One access at a time, fixed read latency,
//            DM priority with a bounded starvation window for IF.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LATENCY = 2,   // command to mem_rdata valid, 1..7
  parameter int ADDR_W  = 16,  // byte address width
  parameter int MAX_DM  = 4    // DM grants in a row while IF waits, 1..7
) (
  input  logic          clk,
  input  logic          rst,   // asynchronous, active-low
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] LAT_C = 3'(LATENCY);
  localparam logic [2:0] MAX_C = 3'(MAX_DM);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        lat_cnt;
  logic [2:0]        starve_cnt;
  logic              owner_dm;      // 1: outstanding read belongs to DM
  logic              grant_if;
  logic              grant_dm;
  logic              is_read;
  logic              lat_done;
  logic              cmd_en;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_we;
  logic [31:0]       cmd_wdata;
  logic              if_rvalid_reg;
  logic              dm_rvalid_reg;
  logic [31:0]       if_rdata_reg;
  logic [31:0]       dm_rdata_reg;

  // Last WAIT cycle: memory data is on mem_rdata right now
  assign lat_done = (state == WAIT) && (lat_cnt == LAT_C);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Arbitration, memory command mux and next state; grants only from IDLE
  // and never while reset is held, so every output is quiet during reset
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    is_read   = 1'b0;
    cmd_en    = 1'b0;
    cmd_addr  = '0;
    cmd_we    = 4'b0000;
    cmd_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (rst) begin
          if (bus.if_req && (!bus.dm_req || (starve_cnt == MAX_C))) grant_if = 1'b1;
          else if (bus.dm_req) grant_dm = 1'b1;
        end
        if (grant_if) begin
          cmd_en    = 1'b1;
          cmd_addr  = bus.if_addr;
          is_read   = 1'b1;
          state_nxt = WAIT;
        end else if (grant_dm) begin
          cmd_en    = 1'b1;
          cmd_addr  = bus.dm_addr;
          cmd_we    = bus.dm_we;
          cmd_wdata = bus.dm_wdata;
          // writes finish in the grant cycle; only reads occupy the memory
          if (bus.dm_we == 4'b0000) begin
            is_read   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter and owner of the outstanding read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt  <= 3'd0;
      owner_dm <= 1'b0;
    end else if (is_read) begin
      lat_cnt  <= 3'd1;
      owner_dm <= grant_dm;
    end else if (lat_done) begin
      lat_cnt  <= 3'd0;
    end else if (state == WAIT) begin
      lat_cnt  <= 3'(lat_cnt + 3'd1);
    end
  end

  // Starvation counter: counts DM wins while IF is waiting, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 3'd0;
    end else if (grant_if) begin
      starve_cnt <= 3'd0;
    end else if (grant_dm) begin
      if (!bus.if_req)               starve_cnt <= 3'd0;
      else if (starve_cnt != MAX_C)  starve_cnt <= 3'(starve_cnt + 3'd1);
    end
  end

  // Read return: capture mem_rdata for the owner, pulse its rvalid next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid_reg <= 1'b0;
      dm_rvalid_reg <= 1'b0;
      if_rdata_reg  <= 32'h0;
      dm_rdata_reg  <= 32'h0;
    end else begin
      if_rvalid_reg <= 1'b0;
      dm_rvalid_reg <= 1'b0;
      if (lat_done) begin
        if (owner_dm) begin
          dm_rdata_reg  <= bus.mem_rdata;
          dm_rvalid_reg <= 1'b1;
        end else begin
          if_rdata_reg  <= bus.mem_rdata;
          if_rvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.mem_en    = cmd_en;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.if_rvalid = if_rvalid_reg;
  assign bus.dm_rvalid = dm_rvalid_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.busy      = (state == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scoreboard bench for mem_arbiter (LATENCY=2, MAX_DM=4).
//            Stimulus pushes expected grants / read returns in order; a
//            negedge monitor pops and compares each event the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 2;

  localparam logic [1:0] K_GIF = 2'd0;
  localparam logic [1:0] K_GDM = 2'd1;
  localparam logic [1:0] K_RIF = 2'd2;
  localparam logic [1:0] K_RDM = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  sbq[$];
  logic [31:0] pipe [LAT];

  mem_arbiter_if #(.ADDR_W(16)) bus ();

  mem_arbiter #(.LATENCY(LAT), .ADDR_W(16), .MAX_DM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: known contents, garbage whenever no read is due
  function automatic logic [31:0] mdata(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  // Memory model pipeline; data is on mem_rdata LAT cycles after the command
  always @(posedge clk) begin
    pipe[0] <= (bus.mem_en && bus.mem_we == 4'b0000) ? mdata(bus.mem_addr)
                                                     : {16'hBAD0, cyc[15:0]};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] a,
                      input logic [3:0] w, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.we = w; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input string nm, input logic ok, input ev_t got);
    ev_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event %h (cycle %0d)", nm, got, cyc);
    end else begin
      e = sbq.pop_front();
      if (!ok || got !== e) begin
        miscompares++;
        $display("FAIL %s: got %h ok=%0b expected %h (cycle %0d)", nm, got, ok, e, cyc);
      end
    end
  endtask

  // Monitor: every grant and every rvalid must match the next expected event
  always @(negedge clk) begin
    ev_t g;
    if (rst === 1'b1) begin
      if (bus.if_rvalid) begin
        g = '{K_RIF, 16'h0, 4'h0, bus.if_rdata};
        sb_check("rv_if", 1'b1, g);
      end
      if (bus.dm_rvalid) begin
        g = '{K_RDM, 16'h0, 4'h0, bus.dm_rdata};
        sb_check("rv_dm", 1'b1, g);
      end
      if (bus.if_gnt || bus.dm_gnt) begin
        g = '{(bus.if_gnt ? K_GIF : K_GDM), bus.mem_addr, bus.mem_we, bus.mem_wdata};
        sb_check("grant", bus.mem_en && !(bus.if_gnt && bus.dm_gnt), g);
      end
    end
  end

  task automatic if_read(input logic [15:0] a, output int gc);
    int n;
    n = 0; gc = -1;
    bus.if_addr = a; bus.if_req = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (bus.if_gnt) begin gc = cyc; break; end
      n++;
    end
    if (gc < 0) chk("if_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.if_addr = '0;
  endtask

  task automatic dm_op(input logic [15:0] a, input logic [3:0] w,
                       input logic [31:0] d, output int gc);
    int n;
    n = 0; gc = -1;
    bus.dm_addr = a; bus.dm_we = w; bus.dm_wdata = d; bus.dm_req = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (bus.dm_gnt) begin gc = cyc; break; end
      n++;
    end
    if (gc < 0) chk("dm_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.dm_req = 1'b0; bus.dm_addr = '0; bus.dm_we = 4'h0; bus.dm_wdata = '0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctrl"}, 64'({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we,
                            bus.if_rvalid, bus.dm_rvalid, bus.busy}), 64'd0);
    chk({nm, "_cmd"},  64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
    chk({nm, "_rdata"}, {bus.if_rdata, bus.dm_rdata}, 64'd0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, g1, g2, ga, gb, gi, gd;
    int gk[5];
    logic [1:0] t2_exp[4];
    t2_exp[0] = 2'b10; t2_exp[1] = 2'b10; t2_exp[2] = 2'b01; t2_exp[3] = 2'b00;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_addr = '0; bus.dm_we = 4'h0; bus.dm_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_quiet("reset_state");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // IF read, data returns at T+3 with busy in T+1..T+2
    s = cyc;
    push(K_GIF, 16'h0010, 4'h0, 32'h0);
    push(K_RIF, 16'h0, 4'h0, 32'hDEADBEEF);
    if_read(16'h0010, g1);
    chk("t2_grant_cycle", 64'(g1), 64'(s));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_busy_rvalid", 64'({bus.busy, bus.if_rvalid}), 64'(t2_exp[i]));
    end
    chk("t2_rdata_hold", 64'(bus.if_rdata), 64'h0000_0000_DEAD_BEEF);
    @(posedge clk); #1;

    // Back-to-back DM writes
    s = cyc;
    push(K_GDM, 16'h0100, 4'b1111, 32'h12345678);
    push(K_GDM, 16'h0104, 4'b0011, 32'hCAFEF00D);
    dm_op(16'h0100, 4'b1111, 32'h12345678, g1);
    dm_op(16'h0104, 4'b0011, 32'hCAFEF00D, g2);
    chk("t3_first_grant", 64'(g1), 64'(s));
    chk("t3_back_to_back", 64'(g2), 64'(g1 + 1));
    @(negedge clk);
    chk("t3_not_busy", 64'(bus.busy), 64'd0);
    repeat (4) @(posedge clk); #1;

    // Simultaneous requests: DM read wins, IF granted as dm_rvalid returns
    s = cyc;
    push(K_GDM, 16'h0200, 4'h0, 32'h0);
    push(K_RDM, 16'h0, 4'h0, 32'hC0DE0200);
    push(K_GIF, 16'h0020, 4'h0, 32'h0);
    push(K_RIF, 16'h0, 4'h0, 32'hC0DE0020);
    fork
      if_read(16'h0020, gi);
      dm_op(16'h0200, 4'h0, 32'h0, gd);
    join
    chk("t4_dm_first", 64'(gd), 64'(s));
    chk("t4_if_after", 64'(gi), 64'(gd + 3));
    repeat (6) @(posedge clk); #1;

    // Starvation: 4 DM grants, then IF, then DM wins the next tie
    s = cyc;
    push(K_GDM, 16'h0300, 4'hF, 32'h11111111);
    push(K_GDM, 16'h0304, 4'hF, 32'h22222222);
    push(K_GDM, 16'h0308, 4'hF, 32'h33333333);
    push(K_GDM, 16'h030C, 4'hF, 32'h44444444);
    push(K_GIF, 16'h0030, 4'h0, 32'h0);
    push(K_RIF, 16'h0, 4'h0, 32'hC0DE0030);
    push(K_GDM, 16'h0310, 4'b0001, 32'h55555555);
    push(K_GIF, 16'h0034, 4'h0, 32'h0);
    push(K_RIF, 16'h0, 4'h0, 32'hC0DE0034);
    fork
      begin
        if_read(16'h0030, ga);
        if_read(16'h0034, gb);
      end
      begin
        dm_op(16'h0300, 4'hF, 32'h11111111, gk[0]);
        dm_op(16'h0304, 4'hF, 32'h22222222, gk[1]);
        dm_op(16'h0308, 4'hF, 32'h33333333, gk[2]);
        dm_op(16'h030C, 4'hF, 32'h44444444, gk[3]);
        dm_op(16'h0310, 4'b0001, 32'h55555555, gk[4]);
      end
    join
    chk("t5_dm_start", 64'(gk[0]), 64'(s));
    chk("t5_if_5th", 64'(ga), 64'(gk[0] + 4));
    chk("t5_dm_wins_tie", 64'(gk[4]), 64'(ga + 3));
    chk("t5_if_next", 64'(gb), 64'(gk[4] + 1));
    repeat (6) @(posedge clk); #1;

    // Reset during a DM read while the data arrives
    push(K_GDM, 16'h0500, 4'h0, 32'h0);
    dm_op(16'h0500, 4'h0, 32'h0, g1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_in_reset", 64'({bus.dm_rvalid, bus.dm_rdata}), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_after_reset", 64'({bus.dm_rvalid, bus.dm_rdata}), 64'd0);
    end
    @(posedge clk); #1;

    // Reset mid-WAIT on an IF read, then the same read again
    push(K_GIF, 16'h0040, 4'h0, 32'h0);
    if_read(16'h0040, g1);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("t1_in_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    s = cyc;
    push(K_GIF, 16'h0040, 4'h0, 32'h0);
    push(K_RIF, 16'h0, 4'h0, 32'hC0DE0040);
    if_read(16'h0040, g2);
    chk("t1_first_idle_grant", 64'(g2), 64'(s));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rvalid_timing", 64'(bus.if_rvalid), 64'(i == 2));
    end

    repeat (6) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
